// File: rtl/router_pkg.sv
// Shared definitions for the router ingress framer: header field layout,
// the reserved destination code and the framer state encoding.
package router_pkg;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HDR   = 3'd2,
    ST_PAYLD = 3'd3,
    ST_PAR   = 3'd4,
    ST_GAP   = 3'd5
  } framer_state_t;

  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] hdr;
    hdr = '0;
    hdr[LEN_MSB:LEN_LSB] = len;
    hdr[ADDR_MSB:0]      = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read,
// contents not reset.
module router_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_framer.sv
// Router ingress framer: buffers a whole payload, then emits header, payload
// and parity back-to-back, honouring the router's busy.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       s_hdr_valid,
  output logic       s_hdr_ready,
  input  logic [1:0] s_hdr_addr,
  input  logic [5:0] s_hdr_len,
  input  logic       s_byte_valid,
  output logic       s_byte_ready,
  input  logic [7:0] s_byte_data,
  input  logic       busy,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_sent,
  output logic       pkt_dropped,
  output logic       framer_idle
);

  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  framer_state_t state;
  logic [1:0]    addr_q;
  logic [5:0]    len_q;
  logic          drop_q;
  logic [5:0]    wr_cnt;
  logic [5:0]    tx_cnt;
  logic [5:0]    rd_ptr;
  logic [5:0]    rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    parity_acc;
  logic [7:0]    gap_cnt;
  logic          hdr_fire;
  logic          byte_fire;
  logic          advance;

  always_comb begin
    s_hdr_ready  = (state == ST_IDLE);
    framer_idle  = (state == ST_IDLE);
    s_byte_ready = (state == ST_LOAD) && (wr_cnt != len_q);
    hdr_fire     = s_hdr_valid && s_hdr_ready;
    byte_fire    = s_byte_valid && s_byte_ready;
    // rd_data always holds buffer[rd_ptr]; step the pointer when the prefetched byte is issued
    advance      = !busy && ((state == ST_HDR) || ((state == ST_PAYLD) && (tx_cnt != len_q)));
    rd_addr      = advance ? rd_ptr + 6'd1 : rd_ptr;
  end

  router_pkt_buf #(
    .DEPTH(MAX_LEN + 1),
    .AW   (6)
  ) u_buf (
    .clock  (clock),
    .wr_en  (byte_fire && !drop_q),
    .wr_addr(wr_cnt),
    .wr_data(s_byte_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      drop_q      <= 1'b0;
      wr_cnt      <= '0;
      tx_cnt      <= '0;
      rd_ptr      <= '0;
      parity_acc  <= '0;
      gap_cnt     <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_sent    <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      pkt_sent    <= 1'b0;
      pkt_dropped <= 1'b0;
      rd_ptr      <= rd_addr;
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            addr_q     <= s_hdr_addr;
            len_q      <= s_hdr_len;
            drop_q     <= (s_hdr_addr == ADDR_INVALID) || (s_hdr_len == 6'd0) ||
                          ({2'b00, s_hdr_len} > 8'(MAX_LEN));
            parity_acc <= make_header(s_hdr_len, s_hdr_addr);
            wr_cnt     <= '0;
            tx_cnt     <= '0;
            rd_ptr     <= '0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byte_fire) begin
            wr_cnt     <= wr_cnt + 6'd1;
            parity_acc <= parity_acc ^ s_byte_data;
          end else if (wr_cnt == len_q) begin
            if (drop_q) begin
              pkt_dropped <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              pkt_data  <= make_header(len_q, addr_q);
              pkt_valid <= 1'b1;
              state     <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (!busy) begin
            pkt_data <= rd_data;
            tx_cnt   <= 6'd1;
            state    <= ST_PAYLD;
          end
        end
        ST_PAYLD: begin
          if (!busy) begin
            if (tx_cnt == len_q) begin
              pkt_data  <= parity_acc;
              pkt_valid <= 1'b0;
              state     <= ST_PAR;
            end else begin
              pkt_data <= rd_data;
              tx_cnt   <= tx_cnt + 6'd1;
            end
          end
        end
        ST_PAR: begin
          if (!busy) begin
            pkt_sent <= 1'b1;
            pkt_data <= '0;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'(GAP_LAST)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Directed bench for router_pkt_framer: a scoreboard of expected output bytes
// is filled when a packet is sent and drained by a negedge monitor.
module tb_router_pkt_framer;

  localparam int GAP = 2;

  logic       clock;
  logic       resetn;
  logic       s_hdr_valid;
  logic       s_hdr_ready;
  logic [1:0] s_hdr_addr;
  logic [5:0] s_hdr_len;
  logic       s_byte_valid;
  logic       s_byte_ready;
  logic [7:0] s_byte_data;
  logic       busy;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_sent;
  logic       pkt_dropped;
  logic       framer_idle;

  router_pkt_framer #(.MAX_LEN(63), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .s_hdr_valid (s_hdr_valid),
    .s_hdr_ready (s_hdr_ready),
    .s_hdr_addr  (s_hdr_addr),
    .s_hdr_len   (s_hdr_len),
    .s_byte_valid(s_byte_valid),
    .s_byte_ready(s_byte_ready),
    .s_byte_data (s_byte_data),
    .busy        (busy),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_sent    (pkt_sent),
    .pkt_dropped (pkt_dropped),
    .framer_idle (framer_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] par_q[$];
  logic [7:0] pay [64];
  int         sent_cnt = 0;
  int         drop_cnt = 0;
  bit         valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: a valid byte is consumed at an edge with busy==0.
  int         cyc = 0;
  int         sent_cyc = 0;
  bit         sent_pend = 0;
  bit         have_sent = 0;
  logic       prev_valid = 0;
  logic       prev_busy = 0;
  logic       prev_idle = 1;
  logic [7:0] prev_data = 0;

  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      prev_valid = 0;
      prev_busy  = 0;
      prev_idle  = 1;
      sent_pend  = 0;
    end else begin
      if (prev_valid && prev_busy && pkt_valid)
        check("hold_while_busy", 32'(pkt_data), 32'(prev_data));
      if (pkt_valid && !busy) begin
        if (exp_q.size() == 0) check("byte_queue_nonempty", 32'(exp_q.size()), 32'd1);
        else check("pkt_byte", 32'(pkt_data), 32'(exp_q.pop_front()));
      end
      if (pkt_valid && !prev_valid && have_sent)
        check("gap_before_header", 32'((cyc - sent_cyc) >= GAP), 32'd1);
      if (pkt_sent) begin
        sent_cnt++;
        if (par_q.size() == 0) check("parity_queue_nonempty", 32'(par_q.size()), 32'd1);
        else check("parity_byte", 32'(prev_data), 32'(par_q.pop_front()));
        check("parity_valid_low", 32'(prev_valid), 32'd0);
        sent_cyc  = cyc;
        sent_pend = 1;
        have_sent = 1;
      end
      if (pkt_dropped) drop_cnt++;
      if (pkt_valid) valid_seen = 1;
      if (framer_idle && !prev_idle && sent_pend) begin
        check("gap_length", 32'(cyc - sent_cyc), 32'(GAP));
        sent_pend = 0;
      end
      prev_valid = pkt_valid;
      prev_busy  = busy;
      prev_idle  = framer_idle;
      prev_data  = pkt_data;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Queue expectations, then hand the command and payload to the DUT.
  task automatic load_packet(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] hdr;
    logic [7:0] par;
    int         n;
    hdr = {l, a};
    par = hdr;
    if (a != 2'b11 && l != 6'd0) begin
      exp_q.push_back(hdr);
      for (int i = 0; i < int'(l); i++) begin
        exp_q.push_back(pay[i]);
        par = par ^ pay[i];
      end
      par_q.push_back(par);
    end
    s_hdr_valid = 1'b1;
    s_hdr_addr  = a;
    s_hdr_len   = l;
    n = 0;
    while (!s_hdr_ready && n < 200) begin tick; n++; end
    check("hdr_ready_in_budget", 32'(s_hdr_ready), 32'd1);
    tick;
    s_hdr_valid = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      s_byte_valid = 1'b1;
      s_byte_data  = pay[i];
      n = 0;
      while (!s_byte_ready && n < 50) begin tick; n++; end
      if (!s_byte_ready) check("byte_ready_in_budget", 32'(s_byte_ready), 32'd1);
      tick;
    end
    s_byte_valid = 1'b0;
  endtask

  // mode 0: busy low; mode 1: random busy; mode 2: busy from per-cycle mask
  task automatic wait_sent(input int mode, input logic [15:0] mask);
    int s0;
    int i;
    s0 = sent_cnt;
    i  = 0;
    while (sent_cnt == s0 && i < 1000) begin
      case (mode)
        0:       busy = 1'b0;
        1:       busy = ($urandom_range(0, 2) == 0);
        default: busy = (i < 16) ? mask[i] : 1'b0;
      endcase
      tick;
      i++;
    end
    busy = 1'b0;
    check("sent_in_budget", 32'(sent_cnt - s0), 32'd1);
  endtask

  task automatic drop_case(input logic [1:0] a, input logic [5:0] l);
    int d0;
    int s0;
    int n;
    d0 = drop_cnt;
    s0 = sent_cnt;
    valid_seen = 0;
    load_packet(a, l);
    n = 0;
    while (drop_cnt == d0 && n < 20) begin tick; n++; end
    repeat (3) tick;
    check("dropped_pulse", 32'(drop_cnt - d0), 32'd1);
    check("drop_no_valid", 32'(valid_seen), 32'd0);
    check("drop_no_sent", 32'(sent_cnt - s0), 32'd0);
    check("drop_back_idle", 32'(framer_idle), 32'd1);
  endtask

  initial begin
    int s0;
    resetn       = 1'b0;
    s_hdr_valid  = 1'b0;
    s_hdr_addr   = '0;
    s_hdr_len    = '0;
    s_byte_valid = 1'b0;
    s_byte_data  = '0;
    busy         = 1'b0;
    tick;
    tick;
    check("rst_hdr_ready", 32'(s_hdr_ready), 32'd1);
    check("rst_idle", 32'(framer_idle), 32'd1);
    check("rst_byte_ready", 32'(s_byte_ready), 32'd0);
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_pkt_data", 32'(pkt_data), 32'd0);
    check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
    check("rst_pkt_dropped", 32'(pkt_dropped), 32'd0);
    resetn = 1'b1;
    tick;

    // Basic packet, no busy
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    s0 = sent_cnt;
    load_packet(2'd1, 6'd3);
    check("load_hdr_ready_low", 32'(s_hdr_ready), 32'd0);
    wait_sent(0, 16'h0);
    repeat (4) tick;
    check("basic_sent_once", 32'(sent_cnt - s0), 32'd1);
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same packet, busy on the header for 2 cycles and on 0x22 for 3
    load_packet(2'd1, 6'd3);
    wait_sent(2, 16'h00E6);
    check("busy_queue_empty", 32'(exp_q.size()), 32'd0);

    // Invalid commands are drained and dropped
    pay[0] = 8'hA5; pay[1] = 8'h5A;
    drop_case(2'd3, 6'd2);
    drop_case(2'd0, 6'd0);

    // Full-length packet with random busy
    for (int i = 0; i < 63; i++) pay[i] = 8'($urandom);
    load_packet(2'd2, 6'd63);
    wait_sent(1, 16'h0);
    check("long_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of the payload
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h40 + i);
    load_packet(2'd0, 6'd5);
    repeat (3) tick;
    check("mid_payld_valid", 32'(pkt_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(pkt_valid), 32'd0);
    check("async_rst_idle", 32'(framer_idle), 32'd1);
    exp_q.delete();
    par_q.delete();
    tick;
    resetn = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hC0 ^ (i * 8'h13));
    load_packet(2'd0, 6'd4);
    wait_sent(0, 16'h0);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back commands
    pay[0] = 8'h01; pay[1] = 8'hFE;
    load_packet(2'd2, 6'd2);
    wait_sent(0, 16'h0);
    check("gap_hdr_ready_low", 32'(s_hdr_ready), 32'd0);
    pay[0] = 8'h77;
    load_packet(2'd1, 6'd1);
    wait_sent(0, 16'h0);
    repeat (4) tick;
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_par_queue_empty", 32'(par_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
